// File: rtl/hms_key_pkg.sv
// Shared types and constants for the push-button conditioning channels.
package hms_key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  // Bit positions inside key_level = {ss, sel, inc, dec}
  localparam int KEY_SS  = 3;
  localparam int KEY_SEL = 2;
  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hms_key_channel.sv
// One key: 2-flop synchroniser, debounce counter, press FSM and, when
// HMS_KEY_AUTOREPEAT_EN is defined and REPEAT_ALLOWED is set, a repeat timer.
module hms_key_channel
  import hms_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit REPEAT_ALLOWED  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o,
  output logic level_o
);

`ifdef HMS_KEY_AUTOREPEAT_EN
  localparam bit AR_BUILD = 1'b1;
`else
  localparam bit AR_BUILD = 1'b0;
`endif
  localparam bit REP_EN = AR_BUILD && REPEAT_ALLOWED;
  localparam int MAXP   = REP_EN ? max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
                                 : DEBOUNCE_CYCLES;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s2_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic          accept_s;
  logic          rep_fire_s;
  key_state_e    state_q, state_d;

  assign s2_s = sync_q[1];

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    state_d  = state_q;
    pulse_d  = 1'b0;
    accept_s = 1'b0;
    // Counter only runs while the synchronised level disagrees with the stable one
    if (s2_s != stable_q) begin
      if (cnt_q == DB_LAST) begin
        accept_s = 1'b1;
        stable_d = s2_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (accept_s && s2_s) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (accept_s && !s2_s) begin
          state_d = IDLE;
        end else if (rep_fire_s) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
        end else begin
          state_d = HELD;
        end
      end
      REPEAT: begin
        if (accept_s && !s2_s) begin
          state_d = IDLE;
        end else if (rep_fire_s) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
        end else begin
          state_d = REPEAT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
    end
  end

`ifdef HMS_KEY_AUTOREPEAT_EN
  if (REP_EN) begin : g_rep
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);
    logic [CW-1:0] rtmr_q, rtmr_d;

    // Timer restarts at every fire and is held at zero outside HELD/REPEAT
    always_comb begin
      rep_fire_s = 1'b0;
      rtmr_d     = '0;
      case (state_q)
        HELD: begin
          if (rtmr_q == RD_LAST) begin
            rep_fire_s = 1'b1;
          end else begin
            rtmr_d = rtmr_q + CW'(1);
          end
        end
        REPEAT: begin
          if (rtmr_q == RR_LAST) begin
            rep_fire_s = 1'b1;
          end else begin
            rtmr_d = rtmr_q + CW'(1);
          end
        end
        default: rtmr_d = '0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rtmr_q <= '0;
      end else begin
        rtmr_q <= rtmr_d;
      end
    end
  end else begin : g_norep
    assign rep_fire_s = 1'b0;
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  assign pulse_o = pulse_q;
  assign level_o = stable_q;

endmodule

// File: rtl/hms_key_conditioner.sv
// Four independent key channels feeding the 12-hour clock's priority wrapper.
// Auto-repeat on inc/dec is compiled in with HMS_KEY_AUTOREPEAT_EN.
module hms_key_conditioner
  import hms_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_raw,
  input  logic       sel_raw,
  input  logic       inc_raw,
  input  logic       dec_raw,
  output logic       ss,
  output logic       sel,
  output logic       inc,
  output logic       dec,
  output logic [3:0] key_level
);

  logic [3:0] raw_s;
  logic [3:0] pulse_s;

  assign raw_s = {ss_raw, sel_raw, inc_raw, dec_raw};

  for (genvar k = 0; k < 4; k++) begin : g_ch
    hms_key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_ALLOWED ((k == KEY_INC) || (k == KEY_DEC))
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_s[k]),
      .pulse_o(pulse_s[k]),
      .level_o(key_level[k])
    );
  end

  assign ss  = pulse_s[KEY_SS];
  assign sel = pulse_s[KEY_SEL];
  assign inc = pulse_s[KEY_INC];
  assign dec = pulse_s[KEY_DEC];

endmodule

// File: tb/tb_hms_key_conditioner.sv
// Directed scenarios plus random key activity, checked cycle by cycle
// against a timing-rule reference model of the four key channels.
module tb_hms_key_conditioner;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RR = 8;
`ifdef HMS_KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;
  logic       ss, sel, inc, dec;
  logic [3:0] key_level;

  int nvec  = 0;
  int nfail = 0;

  // Reference model state
  int         ecnt;
  logic [3:0] rq[$];
  logic [3:0] m_level;
  int         m_diff[4];
  int         m_press[4];

  // Observed-pulse statistics
  int dut_cnt[4];
  int last_edge[4];
  int inc_edges[$];

  always #5 clk = ~clk;

  hms_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_raw   (raw[3]),
    .sel_raw  (raw[2]),
    .inc_raw  (raw[1]),
    .dec_raw  (raw[0]),
    .ss       (ss),
    .sel      (sel),
    .inc      (inc),
    .dec      (dec),
    .key_level(key_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    rq.delete();
    m_level = 4'b0000;
    ecnt    = 0;
    for (int k = 0; k < 4; k++) begin
      m_diff[k]  = 0;
      m_press[k] = 0;
    end
  endtask

  task automatic clr_stats();
    inc_edges.delete();
    for (int k = 0; k < 4; k++) begin
      dut_cnt[k]   = 0;
      last_edge[k] = -1;
    end
  endtask

  // Advance one clock edge, update the model, then compare DUT outputs.
  task automatic step();
    logic [3:0] s;
    logic [3:0] exp_p;
    logic [3:0] obs_p;
    int         t;
    @(posedge clk);
    exp_p = 4'b0000;
    if (rst) begin
      mreset();
    end else begin
      ecnt++;
      rq.push_back(raw);
      if (rq.size() > 3) rq.delete(0);
      s = (rq.size() == 3) ? rq[0] : 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (s[k] != m_level[k]) begin
          m_diff[k]++;
          if (m_diff[k] == D) begin
            m_level[k] = s[k];
            m_diff[k]  = 0;
            if (s[k]) begin
              exp_p[k]   = 1'b1;
              m_press[k] = ecnt;
            end
          end
        end else begin
          m_diff[k] = 0;
        end
        t = ecnt - m_press[k];
        if (AR && (k < 2) && m_level[k] && (t >= RD) && (((t - RD) % RR) == 0))
          exp_p[k] = 1'b1;
      end
    end
    #1;
    obs_p = {ss, sel, inc, dec};
    check("pulses", {28'b0, obs_p}, {28'b0, exp_p});
    check("key_level", {28'b0, key_level}, {28'b0, m_level});
    for (int k = 0; k < 4; k++) begin
      if (obs_p[k]) begin
        dut_cnt[k]++;
        last_edge[k] = ecnt;
        if (k == 1) inc_edges.push_back(ecnt);
      end
    end
  endtask

  initial begin
    int e0;
    int exp1[$];
    clr_stats();
    mreset();

    // Reset state
    repeat (3) step();
    check("reset_outputs", {24'b0, ss, sel, inc, dec, key_level}, 32'b0);
    rst = 1'b0;

    // 1: clean press on inc, held 40 cycles
    raw[1] = 1'b1;
    repeat (40) step();
    raw[1] = 1'b0;
    repeat (12) step();
    if (AR) exp1 = '{6, 22, 30, 38};
    else    exp1 = '{6};
    check("s1_inc_count", inc_edges.size(), exp1.size());
    foreach (exp1[i]) begin
      if (i < inc_edges.size()) check("s1_inc_edge", inc_edges[i], exp1[i]);
    end

    // 2: bouncing press on ss
    clr_stats();
    foreach (exp1[i]) exp1.delete(i);
    exp1 = '{1, 0, 1, 1, 0};
    foreach (exp1[i]) begin
      raw[3] = exp1[i][0];
      step();
    end
    raw[3] = 1'b1;
    e0 = ecnt;
    repeat (12) step();
    check("s2_ss_count", dut_cnt[3], 1);
    check("s2_ss_latency", last_edge[3], e0 + 6);
    raw[3] = 1'b0;
    repeat (12) step();
    check("s2_no_release_pulse", dut_cnt[3], 1);

    // 3: short glitch on sel
    clr_stats();
    raw[2] = 1'b1;
    repeat (3) step();
    raw[2] = 1'b0;
    repeat (10) step();
    check("s3_sel_count", dut_cnt[2], 0);
    check("s3_sel_level", {31'b0, key_level[2]}, 32'd0);

    // 4: simultaneous ss and dec
    clr_stats();
    raw[3] = 1'b1;
    raw[0] = 1'b1;
    e0 = ecnt;
    repeat (10) step();
    check("s4_ss_edge", last_edge[3], e0 + 6);
    check("s4_dec_edge", last_edge[0], e0 + 6);

    // 5: async reset while dec is repeating, keys still held
    repeat (20) step();
    #2;
    rst = 1'b1;
    #1;
    check("s5_rst_async", {24'b0, ss, sel, inc, dec, key_level}, 32'b0);
    step();
    step();
    #2;
    rst = 1'b0;
    clr_stats();
    repeat (8) step();
    check("s5_dec_after_rst", last_edge[0], 6);
    check("s5_ss_after_rst", last_edge[3], 6);

    // 6: release bounce while inc is held
    raw = 4'b0000;
    repeat (12) step();
    clr_stats();
    raw[1] = 1'b1;
    repeat (20) step();
    raw[1] = 1'b0;
    repeat (2) step();
    raw[1] = 1'b1;
    repeat (30) step();
    check("s6_level_held", {31'b0, key_level[1]}, 32'd1);
    raw[1] = 1'b0;
    repeat (12) step();
    check("s6_inc_count", dut_cnt[1], AR ? 6 : 1);

    // Random key activity
    repeat (40) begin
      raw = 4'($urandom);
      repeat ($urandom_range(1, 12)) step();
    end
    raw = 4'b0000;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
